// File: rtl/uart_reg_slave.sv
// UART-attached register-file slave: decodes write (addr|0x80, data) and read (addr)
// commands from an 8O1 serial stream and answers reads after a fixed turnaround.
module uart_reg_slave #(
  parameter int BR      = 434,
  parameter int TA_CYC  = 100,
  parameter int TO_BITS = 20,
  parameter int REG_NUM = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  output logic [REG_NUM*8-1:0] reg_out,
  output logic                 wr_pulse,
  output logic [6:0]           wr_addr,
  output logic                 par_err,
  output logic                 frm_err,
  output logic                 busy
);

  localparam int AW     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int TO_CYC = TO_BITS * BR;
  localparam int CMAX   = (TO_CYC > TA_CYC) ? ((TO_CYC > BR) ? TO_CYC : BR)
                                            : ((TA_CYC > BR) ? TA_CYC : BR);
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [8:0]    BR_M1      = 9'(BR - 1);
  localparam logic [8:0]    BR_HALF_M1 = 9'(BR / 2 - 1);
  localparam logic [CW-1:0] C_BR_M1    = CW'(BR - 1);
  localparam logic [CW-1:0] C_TA_M1    = CW'(TA_CYC - 1);
  localparam logic [CW-1:0] C_TO_M1    = CW'(TO_CYC - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rstate_t;
  typedef enum logic [2:0] {IDLE, GET_DATA, TURNAROUND, TX_START, TX_DATA, TX_PAR, TX_STOP} cstate_t;

  logic       r_rx_s1, r_rx_s2, r_rx_s3;
  rstate_t    r_rstate;
  logic [8:0] r_br_cnt;
  logic [2:0] r_rbit;
  logic [7:0] r_rshift;
  logic       r_rpar;
  logic       r_byte_vld;
  logic [7:0] r_byte;
  logic       w_par_ok;

  cstate_t       r_cstate;
  logic [CW-1:0] r_cnt;
  logic [6:0]    r_addr;
  logic [7:0]    r_tx_shift;
  logic          r_tx_par;
  logic [2:0]    r_tbit;
  logic [7:0]    r_regs [REG_NUM];
  logic          w_addr_ok;
  logic          w_rd_ok;
  logic [7:0]    w_rd_data;

  assign w_par_ok  = ^{r_rshift, r_rpar};
  assign w_addr_ok = int'(r_addr) < REG_NUM;
  assign w_rd_ok   = int'(r_byte[6:0]) < REG_NUM;

  always_comb begin
    w_rd_data = 8'h00;
    if (w_rd_ok) w_rd_data = r_regs[r_byte[AW-1:0]];
  end

  for (genvar k = 0; k < REG_NUM; k++) begin : g_flat
    assign reg_out[8*k +: 8] = r_regs[k];
  end

  // Receiver: synchronizer, edge detect, mid-bit sampling of start/data/parity/stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rstate   <= R_IDLE;
      r_br_cnt   <= '0;
      r_rbit     <= '0;
      r_rshift   <= '0;
      r_rpar     <= 1'b0;
      r_byte_vld <= 1'b0;
      r_byte     <= '0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_byte_vld <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      case (r_rstate)
        R_IDLE: begin
          if (r_rx_s3 && !r_rx_s2) begin
            r_rstate <= R_START;
            r_br_cnt <= '0;
          end
        end
        R_START: begin
          if (r_br_cnt == BR_HALF_M1) begin
            r_br_cnt <= '0;
            r_rbit   <= '0;
            r_rstate <= r_rx_s2 ? R_IDLE : R_DATA;
          end else begin
            r_br_cnt <= r_br_cnt + 9'd1;
          end
        end
        R_DATA: begin
          if (r_br_cnt == BR_M1) begin
            r_br_cnt <= '0;
            r_rshift <= {r_rx_s2, r_rshift[7:1]};
            r_rbit   <= r_rbit + 3'd1;
            if (r_rbit == 3'd7) r_rstate <= R_PAR;
          end else begin
            r_br_cnt <= r_br_cnt + 9'd1;
          end
        end
        R_PAR: begin
          if (r_br_cnt == BR_M1) begin
            r_br_cnt <= '0;
            r_rpar   <= r_rx_s2;
            r_rstate <= R_STOP;
          end else begin
            r_br_cnt <= r_br_cnt + 9'd1;
          end
        end
        R_STOP: begin
          if (r_br_cnt == BR_M1) begin
            r_br_cnt <= '0;
            r_rstate <= R_IDLE;
            par_err  <= !w_par_ok;
            frm_err  <= !r_rx_s2;
            if (w_par_ok && r_rx_s2) begin
              r_byte_vld <= 1'b1;
              r_byte     <= r_rshift;
            end
          end else begin
            r_br_cnt <= r_br_cnt + 9'd1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Command decoder, register bank and read-response transmitter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cstate   <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tbit     <= '0;
      for (int k = 0; k < REG_NUM; k++) r_regs[k] <= 8'h00;
      tx         <= 1'b1;
      wr_pulse   <= 1'b0;
      wr_addr    <= '0;
      busy       <= 1'b0;
    end else begin
      wr_pulse <= 1'b0;
      case (r_cstate)
        IDLE: begin
          if (r_byte_vld) begin
            r_cnt <= '0;
            busy  <= 1'b1;
            if (r_byte[7]) begin
              r_addr   <= r_byte[6:0];
              r_cstate <= GET_DATA;
            end else begin
              // Snapshot now so nothing after acceptance can change the reply
              r_tx_shift <= w_rd_data;
              r_tx_par   <= ~^w_rd_data;
              r_cstate   <= TURNAROUND;
            end
          end
        end
        GET_DATA: begin
          if (r_byte_vld) begin
            if (w_addr_ok) begin
              r_regs[r_addr[AW-1:0]] <= r_byte;
              wr_pulse <= 1'b1;
              wr_addr  <= r_addr;
            end
            r_cstate <= IDLE;
            busy     <= 1'b0;
          end else if (par_err || frm_err || r_cnt == C_TO_M1) begin
            r_cstate <= IDLE;
            busy     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TURNAROUND: begin
          if (r_cnt == C_TA_M1) begin
            r_cnt    <= '0;
            tx       <= 1'b0;
            r_cstate <= TX_START;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TX_START: begin
          if (r_cnt == C_BR_M1) begin
            r_cnt      <= '0;
            tx         <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tbit     <= '0;
            r_cstate   <= TX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (r_cnt == C_BR_M1) begin
            r_cnt <= '0;
            if (r_tbit == 3'd7) begin
              tx       <= r_tx_par;
              r_cstate <= TX_PAR;
            end else begin
              tx         <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tbit     <= r_tbit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TX_PAR: begin
          if (r_cnt == C_BR_M1) begin
            r_cnt    <= '0;
            tx       <= 1'b1;
            r_cstate <= TX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (r_cnt == C_BR_M1) begin
            r_cnt    <= '0;
            r_cstate <= IDLE;
            busy     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cstate <= IDLE;
          busy     <= 1'b0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_slave.sv
// Directed bench for uart_reg_slave: table of write commands, table of read-backs,
// then hand-written timeout, false-start and reset-during-response sequences.
module tb_uart_reg_slave;

  localparam int BR  = 128;
  localparam int TA  = 100;
  localparam int TOB = 20;
  localparam int RN  = 16;
  // rx change -> 3 clk front end -> BR/2 to mid-start -> 10 more bit samples -> TA+1
  localparam int RD_LAT = 3 + BR/2 + 10*BR + TA + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx = 1'b1;
  logic            tx;
  logic [RN*8-1:0] reg_out;
  logic            wr_pulse;
  logic [6:0]      wr_addr;
  logic            par_err;
  logic            frm_err;
  logic            busy;

  uart_reg_slave #(.BR(BR), .TA_CYC(TA), .TO_BITS(TOB), .REG_NUM(RN)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .reg_out(reg_out),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .par_err(par_err),
    .frm_err(frm_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_wr = 0, n_par = 0, n_frm = 0, wr_cyc = -1, bfall_cyc = -1;
  logic busy_d = 1'b0;
  always @(negedge clk) begin
    if (wr_pulse) begin
      n_wr   <= n_wr + 1;
      wr_cyc <= cyc;
    end
    if (par_err) n_par <= n_par + 1;
    if (frm_err) n_frm <= n_frm + 1;
    if (busy_d && !busy) bfall_cyc <= cyc;
    busy_d <= busy;
  end

  int total = 0, bad = 0;
  logic [7:0] model [RN];
  logic [6:0] last_addr;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    bit         bad_par;
    bit         bad_stop;
    int         exp_wr;
    int         exp_par;
    int         exp_frm;
  } wvec_t;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] exp;
  } rvec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] flat();
    logic [127:0] f;
    f = '0;
    for (int k = 0; k < RN; k++) f[8*k +: 8] = model[k];
    return f;
  endfunction

  task automatic to_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           output int t0);
    @(negedge clk);
    t0 = cyc;
    rx = 1'b0;
    repeat (BR) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BR) @(negedge clk);
    end
    rx = (~^b) ^ bad_par;
    repeat (BR) @(negedge clk);
    rx = ~bad_stop;
    repeat (BR) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic get_frame(input int t_ref, input logic [7:0] exp, input string nm);
    int         k, lat;
    logic [7:0] d;
    k = -1;
    for (int i = 0; i < 4*BR + TA; i++) begin
      if (tx === 1'b0) begin
        k = cyc;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (k < 0) begin
      bad++;
      $display("FAIL %s_start: no start bit within %0d clocks", nm, 4*BR + TA);
      return;
    end
    lat = k - t_ref;
    if (lat < RD_LAT - 1 || lat > RD_LAT + 1) begin
      bad++;
      $display("FAIL %s_lat: got %0d want %0d+-1", nm, lat, RD_LAT);
    end
    to_cyc(k + BR/2);
    chk({nm, "_startbit"}, tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      to_cyc(k + BR/2 + (i + 1)*BR);
      d[i] = tx;
    end
    chk({nm, "_data"}, d, exp);
    to_cyc(k + BR/2 + 9*BR);
    chk({nm, "_par"}, tx, ~^exp);
    to_cyc(k + BR/2 + 10*BR);
    chk({nm, "_stop"}, tx, 1'b1);
    to_cyc(k + 11*BR - 1);
    chk({nm, "_busy_hi"}, busy, 1'b1);
    to_cyc(k + 11*BR);
    chk({nm, "_busy_lo"}, busy, 1'b0);
  endtask

  wvec_t wv [8];
  rvec_t rv [5];

  initial begin
    int t0, t1, w0, p0, f0, k;

    wv[0] = '{8'h85, 8'h3C, 0, 0, 1, 0, 0};
    wv[1] = '{8'h8F, 8'hA5, 0, 0, 1, 0, 0};
    wv[2] = '{8'h90, 8'h77, 0, 0, 0, 0, 0};
    wv[3] = '{8'h85, 8'h11, 1, 0, 0, 1, 0};
    wv[4] = '{8'h85, 8'h22, 0, 1, 0, 0, 1};
    wv[5] = '{8'h83, 8'h44, 1, 1, 0, 1, 1};
    wv[6] = '{8'h80, 8'h01, 0, 0, 1, 0, 0};
    wv[7] = '{8'hFF, 8'h99, 0, 0, 0, 0, 0};
    rv[0] = '{8'h05, 8'h3C};
    rv[1] = '{8'h0F, 8'hA5};
    rv[2] = '{8'h00, 8'h01};
    rv[3] = '{8'h10, 8'h00};
    rv[4] = '{8'h7F, 8'h00};
    for (int i = 0; i < RN; i++) model[i] = 8'h00;
    last_addr = 7'd0;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_reg_out", reg_out, 128'h0);
    chk("rst_wr_pulse", wr_pulse, 1'b0);
    chk("rst_wr_addr", wr_addr, 7'd0);
    chk("rst_par_err", par_err, 1'b0);
    chk("rst_frm_err", frm_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      w0 = n_wr; p0 = n_par; f0 = n_frm;
      send_byte(wv[i].b0, 1'b0, 1'b0, t0);
      send_byte(wv[i].b1, wv[i].bad_par, wv[i].bad_stop, t1);
      repeat (2*BR) @(negedge clk);
      if (wv[i].exp_wr != 0) begin
        model[wv[i].b0[3:0]] = wv[i].b1;
        last_addr = wv[i].b0[6:0];
        chk($sformatf("w%0d_busy_fall_with_wr", i), bfall_cyc, wr_cyc);
      end
      chk($sformatf("w%0d_wr_cnt", i), n_wr - w0, wv[i].exp_wr);
      chk($sformatf("w%0d_par_cnt", i), n_par - p0, wv[i].exp_par);
      chk($sformatf("w%0d_frm_cnt", i), n_frm - f0, wv[i].exp_frm);
      chk($sformatf("w%0d_reg_out", i), reg_out, flat());
      chk($sformatf("w%0d_wr_addr", i), wr_addr, last_addr);
      chk($sformatf("w%0d_busy", i), busy, 1'b0);
    end

    for (int i = 0; i < 5; i++) begin
      send_byte(rv[i].cmd, 1'b0, 1'b0, t0);
      get_frame(t0, rv[i].exp, $sformatf("r%0d", i));
      repeat (BR) @(negedge clk);
    end

    // Write address accepted but data never arrives, then a read of register 17
    w0 = n_wr;
    send_byte(8'h83, 1'b0, 1'b0, t0);
    chk("to_busy_after_addr", busy, 1'b1);
    repeat (21*BR) @(negedge clk);
    chk("to_busy_after_timeout", busy, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0, t0);
    get_frame(t0, 8'h00, "to_rd17");
    chk("to_no_write", n_wr - w0, 0);
    chk("to_reg_out", reg_out, flat());

    // 50-clock low glitch must not start a frame
    w0 = n_wr; p0 = n_par; f0 = n_frm;
    repeat (BR) @(negedge clk);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (11*BR) @(negedge clk);
    chk("fs_busy", busy, 1'b0);
    chk("fs_par_cnt", n_par - p0, 0);
    chk("fs_frm_cnt", n_frm - f0, 0);
    chk("fs_wr_cnt", n_wr - w0, 0);

    // Reset asserted during the data bits of a read response
    send_byte(8'h05, 1'b0, 1'b0, t0);
    k = -1;
    for (int i = 0; i < 4*BR + TA; i++) begin
      if (tx === 1'b0) begin
        k = cyc;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (k < 0) begin
      bad++;
      $display("FAIL rmt_start: no start bit within %0d clocks", 4*BR + TA);
    end
    repeat (3*BR + BR/2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmt_tx", tx, 1'b1);
    chk("rmt_busy", busy, 1'b0);
    chk("rmt_reg_out", reg_out, 128'h0);
    chk("rmt_wr_addr", wr_addr, 7'd0);
    for (int i = 0; i < RN; i++) model[i] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (BR) @(negedge clk);
    chk("rmt_tx_idle", tx, 1'b1);
    w0 = n_wr;
    send_byte(8'h85, 1'b0, 1'b0, t0);
    send_byte(8'h3C, 1'b0, 1'b0, t1);
    repeat (2*BR) @(negedge clk);
    model[5] = 8'h3C;
    chk("rmt_wr_cnt", n_wr - w0, 1);
    chk("rmt_reg_out", reg_out, flat());
    chk("rmt_wr_addr_after", wr_addr, 7'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
